fir_filter: RTL and testbench



---
 rtl/fir_filter.sv | 73 +++++++
 tb/tb_fir_filter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fir_filter.sv
// T-tap direct-form FIR with runtime-loadable signed coefficients, one cycle latency.
// Optional build macro FIR_SATURATE_EN clamps the output instead of wrapping it.
module fir_filter #(
  parameter int T  = 4,
  parameter int NI = 8,
  parameter int NO = 2 * NI
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic signed [NI-1:0]     X,
  input  logic [T-1:0][NI-1:0]     W,
  output logic signed [NO-1:0]     Y
);

  // Streaming element: one sample in and one sample out per edge, no valid/ready.
  localparam int PW = 2 * NI;
  localparam int AW = 2 * NI + $clog2(T);

  logic signed [NI-1:0] x_tap [T];
  logic signed [PW-1:0] prod  [T];
  logic signed [AW-1:0] acc;
  logic signed [NO-1:0] y_next;

  assign x_tap[0] = X;

  generate
    if (T > 1) begin : g_dly
      logic signed [NI-1:0] d [1:T-1];

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int k = 1; k < T; k++) d[k] <= '0;
        end else begin
          d[1] <= X;
          for (int k = 2; k < T; k++) d[k] <= d[k-1];
        end
      end

      for (genvar k = 1; k < T; k++) begin : g_tap
        assign x_tap[k] = d[k];
      end
    end
  endgenerate

  // Full-precision multiply-accumulate; no intermediate truncation.
  always_comb begin
    acc = '0;
    for (int k = 0; k < T; k++) begin
      prod[k] = PW'($signed(W[k])) * PW'(x_tap[k]);
      acc     = acc + AW'(prod[k]);
    end
  end

  generate
    if (NO >= AW) begin : g_ext
      assign y_next = NO'(acc);
    end else begin : g_narrow
`ifdef FIR_SATURATE_EN
      logic ovf;
      assign ovf    = (acc[AW-1:NO-1] != {(AW-NO+1){acc[AW-1]}});
      assign y_next = ovf ? {acc[AW-1], {(NO-1){~acc[AW-1]}}} : NO'(acc);
`else
      assign y_next = NO'(acc);
`endif
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) Y <= '0;
    else        Y <= y_next;
  end

endmodule

// File: tb/tb_fir_filter.sv
// Bench for fir_filter (T=4, NI=8, NO=16): directed scenarios plus randomized
// stream compared against an arithmetic reference model.
module tb_fir_filter;

  localparam int T  = 4;
  localparam int NI = 8;
  localparam int NO = 16;

  logic                   clk;
  logic                   rst_n;
  logic signed [NI-1:0]   x;
  logic [T-1:0][NI-1:0]   w;
  logic signed [NO-1:0]   y;

  int n_vec = 0;
  int n_err = 0;
  logic [NO-1:0] exp_q[$];
  int hist [T-1];   // hist[0] = previous sample, hist[1] = two edges ago ...

  fir_filter #(.T(T), .NI(NI), .NO(NO)) dut (
    .CLK(clk), .RST_N(rst_n), .X(x), .W(w), .Y(y)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NO-1:0] got, input logic [NO-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [NO-1:0] to_y(input longint s);
`ifdef FIR_SATURATE_EN
    if (s > 32767)  return 16'h7fff;
    if (s < -32768) return 16'h8000;
`endif
    return s[NO-1:0];
  endfunction

  // Reference: y = sum W[k]*x_k over the live sample and the stored history.
  task automatic tick(input logic signed [NI-1:0] xv);
    longint s;
    x = xv;
    @(posedge clk);
    s = longint'($signed(w[0])) * longint'(xv);
    for (int k = 1; k < T; k++)
      s += longint'($signed(w[k])) * longint'(hist[k-1]);
    for (int k = T-2; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'(xv);
    exp_q.push_back(to_y(s));
    #1;
  endtask

  // Tick, then compare against the model and against a hand-derived constant.
  task automatic tick_chk(input string tag, input logic signed [NI-1:0] xv, input int exp_c);
    logic [NO-1:0] ev;
    tick(xv);
    ev = exp_q.pop_front();
    chk({tag, "_model"}, y, ev);
    chk(tag, y, exp_c[NO-1:0]);
  endtask

  // Asynchronous reset pulse started mid-cycle; held over one edge.
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < T-1; k++) hist[k] = 0;
    #1;
    chk({tag, "_async"}, y, '0);
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, y, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    logic [31:0] t0, t1, t2, t3;
    t0 = w0; t1 = w1; t2 = w2; t3 = w3;
    w = {t3[NI-1:0], t2[NI-1:0], t1[NI-1:0], t0[NI-1:0]};
  endtask

  initial begin
    logic [NO-1:0] ev;
    int sat_hi, sat_lo;
    rst_n = 1'b0;
    x = '0;
    set_w(-2, -1, 3, 4);
    for (int k = 0; k < T-1; k++) hist[k] = 0;
    #3;
    chk("reset_y", y, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // impulse
    tick_chk("imp0", 8'sd1, -2);
    tick_chk("imp1", 8'sd0, -1);
    tick_chk("imp2", 8'sd0, 3);
    tick_chk("imp3", 8'sd0, 4);
    tick_chk("imp4", 8'sd0, 0);
    tick_chk("imp5", 8'sd0, 0);

    // step
    tick_chk("step0", 8'sd1, -2);
    tick_chk("step1", 8'sd1, -3);
    tick_chk("step2", 8'sd1, 0);
    tick_chk("step3", 8'sd1, 4);
    tick_chk("step4", 8'sd1, 4);
    tick_chk("step5", 8'sd1, 4);

    // mid-stream reset: no pre-reset history may reappear
    pulse_reset("mid_rst");
    tick_chk("post0", 8'sd1, -2);
    tick_chk("post1", 8'sd1, -3);
    tick_chk("post2", 8'sd1, 0);
    tick_chk("post3", 8'sd1, 4);

    // reset with X=5 applied, then first edge after release
    x = 8'sd5;
    pulse_reset("rst_x5");
    tick_chk("rel_x5", 8'sd5, -10);

    // modular stream from reset
    pulse_reset("mod_rst");
    tick_chk("mod0", 8'sd0, 0);
    tick_chk("mod1", 8'sd9, -18);
    tick_chk("mod2", 8'sd18, -45);
    tick_chk("mod3", 8'sd8, -7);
    tick_chk("mod4", 8'sd17, 48);

    // overflow: 64516 and -65024
`ifdef FIR_SATURATE_EN
    sat_hi = 32767;  sat_lo = -32768;
`else
    sat_hi = -1020;  sat_lo = 512;
`endif
    pulse_reset("ovf_rst");
    set_w(127, 127, 127, 127);
    for (int i = 0; i < 3; i++) begin
      tick(8'sd127);
      ev = exp_q.pop_front();
      chk("ovf_hi_ramp", y, ev);
    end
    tick_chk("ovf_hi", 8'sd127, sat_hi);
    pulse_reset("ovf_rst2");
    for (int i = 0; i < 3; i++) begin
      tick(-8'sd128);
      ev = exp_q.pop_front();
      chk("ovf_lo_ramp", y, ev);
    end
    tick_chk("ovf_lo", -8'sd128, sat_lo);

    // randomized stream with coefficient changes and occasional resets
    for (int i = 0; i < 400; i++) begin
      logic signed [NI-1:0] xv;
      if ($urandom_range(0, 7) == 0)
        w = {$urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 255)};
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) w = {4{8'h7f}};
        else                           w = {4{8'h80}};
      end
      case ($urandom_range(0, 5))
        0:       xv = 8'sh7f;
        1:       xv = -8'sh80;
        default: xv = NI'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 49) == 0) pulse_reset("rand_rst");
      tick(xv);
      ev = exp_q.pop_front();
      chk("rand", y, ev);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
